// File: rtl/riscv_pkg.sv
// Shared types and helpers for the data-memory controller.
// Lane shifting is written once here so the aligner and any future users agree on lane order.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SECOND,
        RESP
    } dmem_state_t;

    // Widest supported lane count (XLEN up to 128).
    localparam int LANE_MAX = 16;

    function automatic logic [2*LANE_MAX-1:0] lane_shift(
        input logic [LANE_MAX-1:0] strobe,
        input logic [3:0]          o
    );
        lane_shift = {{LANE_MAX{1'b0}}, strobe} << o;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane aligner: moves CPU lane-ordered strobes and data onto two SRAM words,
// and moves the two-word SRAM read data back into CPU lane order.
module dmem_lane_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int BYTES = XLEN / 8,
    localparam int OFS = $clog2(BYTES)
) (
    input  logic [OFS-1:0]   ofs,
    input  logic [BYTES-1:0] strobe,
    input  logic [XLEN-1:0]  din,
    input  logic [XLEN-1:0]  rd0,
    input  logic [XLEN-1:0]  rd1,
    output logic [BYTES-1:0] s_lo,
    output logic [BYTES-1:0] s_hi,
    output logic [XLEN-1:0]  d_lo,
    output logic [XLEN-1:0]  d_hi,
    output logic             split,
    output logic [XLEN-1:0]  rdata
);

    logic [2*LANE_MAX-1:0] s_full;
    logic [2*XLEN-1:0]     d_full;
    logic [2*XLEN-1:0]     rd_full;
    logic [XLEN-1:0]       lane_mask;
    logic                  unused_s;

    always_comb begin
        s_full  = lane_shift(LANE_MAX'(strobe), 4'(ofs));
        d_full  = {{XLEN{1'b0}}, din} << {ofs, 3'b000};
        rd_full = {rd1, rd0} >> {ofs, 3'b000};
        for (int i = 0; i < BYTES; i++) begin
            lane_mask[8*i +: 8] = {8{strobe[i]}};
        end
    end

    assign s_lo     = s_full[BYTES-1:0];
    assign s_hi     = s_full[2*BYTES-1:BYTES];
    assign split    = |s_hi;
    assign d_lo     = d_full[XLEN-1:0];
    assign d_hi     = d_full[2*XLEN-1:XLEN];
    // Lanes the CPU did not strobe read back as zero.
    assign rdata    = rd_full[XLEN-1:0] & lane_mask;
    assign unused_s = ^s_full[2*LANE_MAX-1:2*BYTES];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: maps byte-lane CPU requests of any alignment onto a word-wide
// 1-cycle-latency SRAM, splitting word-crossing accesses into two ops and stalling the CPU meanwhile.
module dmem_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN/8-1:0] mem_r,
    input  logic [XLEN/8-1:0] mem_w,
    input  logic [XLEN-1:0]   mem_din,
    output logic [XLEN-1:0]   mem_dout,
    output logic              mem_stall,
    output logic              sram_en,
    output logic [XLEN/8-1:0] sram_we,
    output logic [AW-1:0]     sram_addr,
    output logic [XLEN-1:0]   sram_wdata,
    input  logic [XLEN-1:0]   sram_rdata
);

    localparam int BYTES = XLEN / 8;
    localparam int OFS   = $clog2(BYTES);

    // Handshake: while mem_stall=1 the CPU holds mem_addr/mem_r/mem_w/mem_din stable;
    // the cycle mem_stall drops (RESP) is the completion cycle and mem_dout is valid then.

    dmem_state_t state, state_next;

    logic             req;
    logic             req_write;
    logic [BYTES-1:0] req_strobe;
    logic [AW-1:0]    w0;

    logic [OFS-1:0]   ofs_q;
    logic [BYTES-1:0] strobe_q;
    logic [XLEN-1:0]  din_q;
    logic             is_write_q;
    logic             split_q;
    logic [AW-1:0]    w1_q;
    logic [XLEN-1:0]  rd0_q;
    logic [XLEN-1:0]  dout_q;

    logic [OFS-1:0]   a_ofs;
    logic [BYTES-1:0] a_strobe;
    logic [XLEN-1:0]  a_din;
    logic [XLEN-1:0]  a_rd0;
    logic [BYTES-1:0] s_lo, s_hi;
    logic [XLEN-1:0]  d_lo, d_hi;
    logic             split;
    logic [XLEN-1:0]  align_rdata;
    logic [XLEN-1:0]  resp_data;
    logic             unused_addr;

    assign req         = (|mem_w) || (|mem_r);
    assign req_write   = |mem_w;
    assign req_strobe  = req_write ? mem_w : mem_r;
    assign w0          = mem_addr[OFS +: AW];
    assign unused_addr = ^mem_addr[XLEN-1:OFS+AW];

    // IDLE works on the live request; later states on the latched copy.
    assign a_ofs    = (state == IDLE) ? mem_addr[OFS-1:0] : ofs_q;
    assign a_strobe = (state == IDLE) ? req_strobe : strobe_q;
    assign a_din    = (state == IDLE) ? mem_din : din_q;
    assign a_rd0    = split_q ? rd0_q : sram_rdata;

    dmem_lane_align #(.XLEN(XLEN)) u_align (
        .ofs    (a_ofs),
        .strobe (a_strobe),
        .din    (a_din),
        .rd0    (a_rd0),
        .rd1    (sram_rdata),
        .s_lo   (s_lo),
        .s_hi   (s_hi),
        .d_lo   (d_lo),
        .d_hi   (d_hi),
        .split  (split),
        .rdata  (align_rdata)
    );

    always_comb begin
        state_next = state;
        sram_en    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        mem_stall  = 1'b0;
        resp_data  = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    sram_en    = 1'b1;
                    sram_addr  = w0;
                    sram_we    = req_write ? s_lo : '0;
                    sram_wdata = d_lo;
                    mem_stall  = 1'b1;
                    state_next = split ? SECOND : RESP;
                end
            end
            SECOND: begin
                sram_en    = 1'b1;
                sram_addr  = w1_q;
                sram_we    = is_write_q ? s_hi : '0;
                sram_wdata = d_hi;
                mem_stall  = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_data  = is_write_q ? '0 : align_rdata;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Reset suppresses any op that would otherwise issue this cycle.
        if (rst) begin
            sram_en   = 1'b0;
            sram_we   = '0;
            mem_stall = 1'b0;
        end
    end

    assign mem_dout = (state == RESP && !rst) ? resp_data : dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ofs_q      <= '0;
            strobe_q   <= '0;
            din_q      <= '0;
            is_write_q <= 1'b0;
            split_q    <= 1'b0;
            w1_q       <= '0;
            rd0_q      <= '0;
            dout_q     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req) begin
                ofs_q      <= mem_addr[OFS-1:0];
                strobe_q   <= req_strobe;
                din_q      <= mem_din;
                is_write_q <= req_write;
                split_q    <= split;
                w1_q       <= w0 + 1'b1;
            end
            if (state == SECOND) begin
                rd0_q <= sram_rdata;
            end
            if (state == RESP) begin
                dout_q <= resp_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a byte-addressed 1-cycle-latency SRAM model.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_dmem_ctrl;

    localparam int XLEN  = 32;
    localparam int AW    = 10;
    localparam int BYTES = XLEN / 8;

    logic              clk;
    logic              rst;
    logic [XLEN-1:0]   mem_addr;
    logic [BYTES-1:0]  mem_r;
    logic [BYTES-1:0]  mem_w;
    logic [XLEN-1:0]   mem_din;
    logic [XLEN-1:0]   mem_dout;
    logic              mem_stall;
    logic              sram_en;
    logic [BYTES-1:0]  sram_we;
    logic [AW-1:0]     sram_addr;
    logic [XLEN-1:0]   sram_wdata;
    logic [XLEN-1:0]   sram_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] mem [0:4095];

    dmem_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_addr   (mem_addr),
        .mem_r      (mem_r),
        .mem_w      (mem_w),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_stall  (mem_stall),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // SRAM model: reads return the word on the next cycle, writes honour byte enables.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == '0) begin
                sram_rdata <= {mem[{sram_addr, 2'd3}], mem[{sram_addr, 2'd2}],
                               mem[{sram_addr, 2'd1}], mem[{sram_addr, 2'd0}]};
            end else begin
                for (int i = 0; i < BYTES; i++) begin
                    if (sram_we[i]) mem[{sram_addr, 2'(i)}] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // driver tasks
    task automatic drive_req(input logic [XLEN-1:0] a, input logic [BYTES-1:0] r,
                             input logic [BYTES-1:0] w, input logic [XLEN-1:0] d);
        mem_addr = a;
        mem_r    = r;
        mem_w    = w;
        mem_din  = d;
    endtask

    task automatic drive_idle();
        drive_req('0, '0, '0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({sram_en, sram_we, mem_stall} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: en/we/stall got %b expected 000000", {sram_en, sram_we, mem_stall});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({sram_en, mem_stall, mem_dout} !== {2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_idle: en=%b stall=%b dout=%h expected 0 0 00000000",
                     sram_en, mem_stall, mem_dout);
        end
    endtask

    task automatic test_sw_aligned();
        @(negedge clk);
        drive_req(32'd12, 4'h0, 4'hF, 32'd321);
        #1;
        tests_run++;
        if ({sram_en, sram_we, sram_addr, mem_stall} !== {1'b1, 4'hF, 10'd3, 1'b1}) begin
            tests_failed++;
            $display("FAIL sw_op0: en=%b we=%b addr=%0d stall=%b expected 1 1111 3 1",
                     sram_en, sram_we, sram_addr, mem_stall);
        end
        tests_run++;
        if (sram_wdata !== 32'h0000_0141) begin
            tests_failed++;
            $display("FAIL sw_wdata: got %h expected 00000141", sram_wdata);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({sram_en, mem_stall, mem_dout} !== {2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL sw_resp: en=%b stall=%b dout=%h expected 0 0 00000000",
                     sram_en, mem_stall, mem_dout);
        end
        tests_run++;
        if ({mem[15], mem[14], mem[13], mem[12]} !== 32'h0000_0141) begin
            tests_failed++;
            $display("FAIL sw_mem: got %h expected 00000141", {mem[15], mem[14], mem[13], mem[12]});
        end
    endtask

    task automatic test_lb();
        @(negedge clk);
        drive_req(32'd0, 4'h0, 4'hF, 32'h0000_DF7B);
        @(negedge clk);
        @(negedge clk);
        drive_req(32'd1, 4'b0001, 4'h0, 32'h0);
        #1;
        tests_run++;
        if ({sram_en, sram_we, sram_addr, mem_stall} !== {1'b1, 4'h0, 10'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL lb_op0: en=%b we=%b addr=%0d stall=%b expected 1 0000 0 1",
                     sram_en, sram_we, sram_addr, mem_stall);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({mem_stall, mem_dout} !== {1'b0, 32'h0000_00DF}) begin
            tests_failed++;
            $display("FAIL lb_resp: stall=%b dout=%h expected 0 000000df", mem_stall, mem_dout);
        end
        @(negedge clk);
        drive_idle();
        #1;
        tests_run++;
        if (mem_dout !== 32'h0000_00DF) begin
            tests_failed++;
            $display("FAIL lb_hold: dout got %h expected 000000df", mem_dout);
        end
    endtask

    task automatic test_split_write();
        @(negedge clk);
        drive_req(32'd6, 4'h0, 4'hF, 32'hAABB_CCDD);
        #1;
        tests_run++;
        if ({sram_en, sram_we, sram_addr, mem_stall} !== {1'b1, 4'b1100, 10'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL split_op0: en=%b we=%b addr=%0d stall=%b expected 1 1100 1 1",
                     sram_en, sram_we, sram_addr, mem_stall);
        end
        tests_run++;
        if (sram_wdata[31:16] !== 16'hCCDD) begin
            tests_failed++;
            $display("FAIL split_wdata0: got %h expected ccdd", sram_wdata[31:16]);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({sram_en, sram_we, sram_addr, mem_stall} !== {1'b1, 4'b0011, 10'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL split_op1: en=%b we=%b addr=%0d stall=%b expected 1 0011 2 1",
                     sram_en, sram_we, sram_addr, mem_stall);
        end
        tests_run++;
        if (sram_wdata[15:0] !== 16'hAABB) begin
            tests_failed++;
            $display("FAIL split_wdata1: got %h expected aabb", sram_wdata[15:0]);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({sram_en, mem_stall} !== 2'b00) begin
            tests_failed++;
            $display("FAIL split_resp: en=%b stall=%b expected 0 0", sram_en, mem_stall);
        end
        tests_run++;
        if ({mem[9], mem[8], mem[7], mem[6]} !== 32'hAABB_CCDD) begin
            tests_failed++;
            $display("FAIL split_mem: got %h expected aabbccdd", {mem[9], mem[8], mem[7], mem[6]});
        end
    endtask

    // Read issued in the IDLE cycle right after the write's RESP.
    task automatic test_back_to_back();
        @(negedge clk);
        drive_req(32'd6, 4'hF, 4'h0, 32'h0);
        #1;
        tests_run++;
        if ({sram_en, sram_we, sram_addr, mem_stall} !== {1'b1, 4'h0, 10'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL b2b_op0: en=%b we=%b addr=%0d stall=%b expected 1 0000 1 1",
                     sram_en, sram_we, sram_addr, mem_stall);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({sram_en, sram_we, sram_addr, mem_stall} !== {1'b1, 4'h0, 10'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL b2b_op1: en=%b we=%b addr=%0d stall=%b expected 1 0000 2 1",
                     sram_en, sram_we, sram_addr, mem_stall);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({mem_stall, mem_dout} !== {1'b0, 32'hAABB_CCDD}) begin
            tests_failed++;
            $display("FAIL b2b_resp: stall=%b dout=%h expected 0 aabbccdd", mem_stall, mem_dout);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        drive_req(32'h0000_0FFF, 4'h0, 4'b0011, 32'h0000_BEEF);
        #1;
        tests_run++;
        if ({sram_en, sram_we, sram_addr, mem_stall} !== {1'b1, 4'b1000, 10'd1023, 1'b1}) begin
            tests_failed++;
            $display("FAIL wrap_op0: en=%b we=%b addr=%0d stall=%b expected 1 1000 1023 1",
                     sram_en, sram_we, sram_addr, mem_stall);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({sram_en, sram_we, sram_addr, sram_wdata[7:0]} !== {1'b1, 4'b0001, 10'd0, 8'hBE}) begin
            tests_failed++;
            $display("FAIL wrap_op1: en=%b we=%b addr=%0d wdata=%h expected 1 0001 0 be",
                     sram_en, sram_we, sram_addr, sram_wdata[7:0]);
        end
        @(negedge clk);
        @(negedge clk);
        drive_req(32'h0000_0FFF, 4'b0011, 4'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if ({mem_stall, mem_dout} !== {1'b0, 32'h0000_BEEF}) begin
            tests_failed++;
            $display("FAIL wrap_read: stall=%b dout=%h expected 0 0000beef", mem_stall, mem_dout);
        end
    endtask

    task automatic test_rw_both();
        @(negedge clk);
        drive_req(32'd0, 4'hF, 4'hF, 32'h1234_5678);
        #1;
        tests_run++;
        if ({sram_en, sram_we, sram_addr, mem_stall} !== {1'b1, 4'hF, 10'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL rw_op0: en=%b we=%b addr=%0d stall=%b expected 1 1111 0 1",
                     sram_en, sram_we, sram_addr, mem_stall);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({mem_stall, mem_dout} !== {1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL rw_resp: stall=%b dout=%h expected 0 00000000", mem_stall, mem_dout);
        end
        @(negedge clk);
        drive_idle();
        #1;
        tests_run++;
        if ({mem[3], mem[2], mem[1], mem[0]} !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL rw_mem: got %h expected 12345678", {mem[3], mem[2], mem[1], mem[0]});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_req(32'd6, 4'h0, 4'hF, 32'h1122_3344);
        @(negedge clk);
        #1;
        tests_run++;
        if ({sram_en, sram_we, sram_addr, mem_stall} !== {1'b1, 4'b0011, 10'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL rstmid_second: en=%b we=%b addr=%0d stall=%b expected 1 0011 2 1",
                     sram_en, sram_we, sram_addr, mem_stall);
        end
        rst = 1'b1;
        drive_idle();
        #1;
        tests_run++;
        if ({sram_en, sram_we, mem_stall} !== 6'b0) begin
            tests_failed++;
            $display("FAIL rstmid_gate: en/we/stall got %b expected 000000", {sram_en, sram_we, mem_stall});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if ({sram_en, mem_stall, mem_dout} !== {2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL rstmid_idle: en=%b stall=%b dout=%h expected 0 0 00000000",
                     sram_en, mem_stall, mem_dout);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({mem[9], mem[8], mem[7], mem[6]} !== 32'hAABB_3344) begin
            tests_failed++;
            $display("FAIL rstmid_mem: got %h expected aabb3344", {mem[9], mem[8], mem[7], mem[6]});
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_sw_aligned();
        test_lb();
        test_split_write();
        test_back_to_back();
        test_wrap();
        test_rw_both();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
